// File: rtl/alu_sequencer.sv
// Repeats one 8-bit ALU function against the ALUOut register, once per clock, for Count+1 commits.
// B is always ALUOut[3:0]. Func, A and Count are captured on an accepted Start rising edge.
module alu_sequencer #(
  parameter int         CNT_W     = 4,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic             Clock,
  input  logic             Reset_b,
  input  logic             Start,
  input  logic             Clear,
  input  logic [2:0]       Func,
  input  logic [3:0]       A,
  input  logic [CNT_W-1:0] Count,
  output logic [7:0]       ALUOut,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Iter
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic       start_q;
  logic       start_edge;
  logic [2:0] func_q;
  logic [3:0] a_q;

  function automatic logic [7:0] alu_op(input logic [2:0] f, input logic [3:0] a,
                                        input logic [7:0] r);
    logic [3:0] b;
    logic [4:0] sum;
    b   = r[3:0];
    sum = {1'b0, a} + {1'b0, b};
    case (f)
      3'd0:    alu_op = {3'b000, sum};
      3'd1:    alu_op = {a ^ b, a | b};
      3'd2:    alu_op = {7'b0, |(a | b)};
      3'd3:    alu_op = {a, ~b};
      3'd4:    alu_op = r << a[2:0];
      3'd5:    alu_op = r >> a[2:0];
      3'd6:    alu_op = {4'b0000, a} * {4'b0000, b};
      default: alu_op = r;
    endcase
  endfunction

  assign start_edge = Start & ~start_q;

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) state <= IDLE;
    else          state <= state_nxt;
  end

  // Clear outranks everything, so a start edge coinciding with it is simply lost.
  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: if (start_edge) state_nxt = RUN;
      RUN: begin
        Busy = 1'b1;
        if (Iter == '0) state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (Clear) state_nxt = IDLE;
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      start_q <= 1'b0;
      ALUOut  <= RESET_VAL;
      func_q  <= 3'd0;
      a_q     <= 4'd0;
      Iter    <= '0;
    end else begin
      start_q <= Start;
      if (Clear) begin
        ALUOut <= RESET_VAL;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge) begin
              func_q <= Func;
              a_q    <= A;
              Iter   <= Count;
            end
          end
          RUN: begin
            ALUOut <= alu_op(func_q, a_q, ALUOut);
            if (Iter != '0) Iter <= Iter - CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a table of chained runs plus hand-built sequences
// for reset mid-run, clear priority, ignored start edges and per-cycle traces.
module tb_alu_sequencer;

  logic       Clock, Reset_b, Start, Clear;
  logic [2:0] Func;
  logic [3:0] A, Count, Iter;
  logic [7:0] ALUOut;
  logic       Busy, Done;

  alu_sequencer #(.CNT_W(4), .RESET_VAL(8'h00)) dut (
    .Clock(Clock), .Reset_b(Reset_b), .Start(Start), .Clear(Clear),
    .Func(Func), .A(A), .Count(Count),
    .ALUOut(ALUOut), .Busy(Busy), .Done(Done), .Iter(Iter)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    bit         clr;
    logic [2:0] f;
    logic [3:0] a;
    logic [3:0] c;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl[20];
  logic [7:0] tr[0:23];
  logic [3:0] itr[0:23];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
  endtask

  // Launches one run, scrambles the inputs after acceptance, and samples every cycle.
  task automatic run(input logic [2:0] f, input logic [3:0] a, input logic [3:0] c,
                     input bit retog, output logic [7:0] fin, output int busy_n,
                     output int done_n, output int done_at);
    Func = f; A = a; Count = c; Start = 1'b1;
    tick();
    Start = 1'b0; Func = ~f; A = ~a; Count = ~c;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < int'(c) + 4; i++) begin
      tr[i]  = ALUOut;
      itr[i] = Iter;
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (retog && i == 1) Start = 1'b1;
      if (retog && i == 2) Start = 1'b0;
      tick();
    end
    fin = ALUOut;
  endtask

  initial begin
    logic [7:0] fin;
    int         bn, dn, da, bad;

    tbl[0]  = '{1'b1, 3'd0, 4'h3, 4'd2,  8'h09};
    tbl[1]  = '{1'b1, 3'd0, 4'h5, 4'd0,  8'h05};
    tbl[2]  = '{1'b0, 3'd3, 4'hA, 4'd0,  8'hAA};
    tbl[3]  = '{1'b1, 3'd0, 4'h3, 4'd0,  8'h03};
    tbl[4]  = '{1'b0, 3'd6, 4'h5, 4'd1,  8'h4B};
    tbl[5]  = '{1'b0, 3'd1, 4'h6, 4'd0,  8'hDF};
    tbl[6]  = '{1'b0, 3'd2, 4'h0, 4'd0,  8'h01};
    tbl[7]  = '{1'b1, 3'd2, 4'h0, 4'd0,  8'h00};
    tbl[8]  = '{1'b0, 3'd0, 4'hF, 4'd1,  8'h1E};
    tbl[9]  = '{1'b0, 3'd5, 4'h2, 4'd0,  8'h07};
    tbl[10] = '{1'b0, 3'd4, 4'h9, 4'd2,  8'h38};
    tbl[11] = '{1'b0, 3'd4, 4'h3, 4'd1,  8'h00};
    tbl[12] = '{1'b0, 3'd0, 4'h4, 4'd0,  8'h04};
    tbl[13] = '{1'b0, 3'd7, 4'h7, 4'd3,  8'h04};
    tbl[14] = '{1'b0, 3'd0, 4'h1, 4'd15, 8'h04};
    tbl[15] = '{1'b0, 3'd6, 4'hF, 4'd0,  8'h3C};
    tbl[16] = '{1'b0, 3'd6, 4'hF, 4'd0,  8'hB4};
    tbl[17] = '{1'b0, 3'd5, 4'h7, 4'd0,  8'h01};
    tbl[18] = '{1'b0, 3'd3, 4'h0, 4'd0,  8'h0E};
    tbl[19] = '{1'b0, 3'd1, 4'h3, 4'd0,  8'hDF};

    Reset_b = 1'b0; Start = 1'b0; Clear = 1'b0; Func = 3'd0; A = 4'd0; Count = 4'd0;
    repeat (2) @(posedge Clock);
    #1 Reset_b = 1'b1;
    tick();
    chk("reset_aluout", ALUOut, 8'h00);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_iter", Iter, 0);

    // Accumulate with per-cycle trace of result and remaining iterations
    do_clear();
    run(3'd0, 4'h3, 4'd2, 1'b0, fin, bn, dn, da);
    chk("acc_tr1", tr[1], 8'h03);
    chk("acc_tr2", tr[2], 8'h06);
    chk("acc_tr3", tr[3], 8'h09);
    chk("acc_iter0", itr[0], 2);
    chk("acc_iter1", itr[1], 1);
    chk("acc_iter2", itr[2], 0);
    chk("acc_busy", bn, 3);
    chk("acc_done", dn, 1);
    chk("acc_done_at", da, 3);

    // Product chain
    do_clear();
    run(3'd0, 4'h3, 4'd0, 1'b0, fin, bn, dn, da);
    run(3'd6, 4'h5, 4'd1, 1'b0, fin, bn, dn, da);
    chk("prod_tr1", tr[1], 8'h0F);
    chk("prod_tr2", tr[2], 8'h4B);

    // Shift with a second start edge during RUN that must be ignored
    do_clear();
    run(3'd0, 4'h1, 4'd0, 1'b0, fin, bn, dn, da);
    run(3'd4, 4'h1, 4'd3, 1'b1, fin, bn, dn, da);
    chk("shl_tr1", tr[1], 8'h02);
    chk("shl_tr2", tr[2], 8'h04);
    chk("shl_tr3", tr[3], 8'h08);
    chk("shl_tr4", tr[4], 8'h10);
    chk("shl_done", dn, 1);
    bad = 0;
    repeat (4) begin
      if (Busy || Done) bad++;
      tick();
    end
    chk("shl_no_rerun", bad, 0);
    chk("shl_hold", ALUOut, 8'h10);

    // Asynchronous reset in the middle of a run
    Func = 3'd0; A = 4'h3; Count = 4'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    chk("mid_busy_pre", Busy, 1);
    Reset_b = 1'b0;
    #1;
    chk("arst_aluout", ALUOut, 8'h00);
    chk("arst_busy", Busy, 0);
    chk("arst_iter", Iter, 0);
    tick();
    Reset_b = 1'b1;
    bad = 0;
    repeat (4) begin
      if (Busy || Done) bad++;
      tick();
    end
    chk("arst_idle", bad, 0);
    chk("arst_hold", ALUOut, 8'h00);

    // Clear and a start edge in the same cycle during RUN
    Func = 3'd0; A = 4'h3; Count = 4'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    chk("clr_busy_pre", Busy, 1);
    chk("clr_pre_val", ALUOut, 8'h03);
    Clear = 1'b1; Start = 1'b1;
    tick();
    Clear = 1'b0;
    chk("clr_aluout", ALUOut, 8'h00);
    chk("clr_busy", Busy, 0);
    chk("clr_done", Done, 0);
    bad = 0;
    repeat (5) begin
      if (Busy || Done) bad++;
      tick();
    end
    chk("clr_held_start", bad, 0);
    chk("clr_hold", ALUOut, 8'h00);
    Start = 1'b0;
    tick();

    // Chained table of runs covering every function
    for (int k = 0; k < 20; k++) begin
      if (tbl[k].clr) do_clear();
      run(tbl[k].f, tbl[k].a, tbl[k].c, 1'b0, fin, bn, dn, da);
      chk($sformatf("vec%0d_result", k), fin, tbl[k].exp);
      chk($sformatf("vec%0d_busy", k), bn, int'(tbl[k].c) + 1);
      chk($sformatf("vec%0d_done", k), dn, 1);
      chk($sformatf("vec%0d_done_at", k), da, int'(tbl[k].c) + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Controller that drives the board's 8-bit ALU repeatedly against an internal result register (ALUOut) to build multi-step results from switch inputs.
- On a start request it latches the function select, the 4-bit A operand and a repeat count.
- It then executes the selected ALU function count+1 times, one commit per clock. The ALU B operand is always ALUOut[3:0].
- Sits between the SW/KEY inputs and the LEDR/HEX displays in the ALU lab top level.

Parameters:
- CNT_W, 4, width of repeat-count input and internal iteration counter.
- RESET_VAL, 8'h00, value loaded into ALUOut on reset and on clear.

Ports:
- Clock  input  1  system clock, all state updates on rising edge.
- Reset_b  input  1  asynchronous, active-low reset.
- Start  input  1  level input. A rising edge, detected internally, requests a run.
- Clear  input  1  synchronous. Loads RESET_VAL into ALUOut and forces IDLE. Highest priority after reset.
- Func  input  3  ALU function select, sampled at accepted start.
- A  input  4  ALU A operand, sampled at accepted start.
- Count  input  CNT_W  repeat count. Number of iterations is Count+1. Sampled at accepted start.
- ALUOut  output  8  result register.
- Busy  output  1  high while in RUN.
- Done  output  1  one-cycle pulse in DONE state.
- Iter  output  CNT_W  remaining iterations after the current one. Valid while Busy.

Behaviour:
- Reset (Reset_b=0, async): state=IDLE, ALUOut=RESET_VAL, Busy=0, Done=0, Iter=0, start-edge register=0, latched Func/A/Count=0. Reset may arrive in any state, including mid-RUN; the partial result is discarded.
- Start edge: start_q registers Start every cycle. An edge is Start & ~start_q.
- States:
  - IDLE: on edge, latch Func, A, Count; Iter<=Count; go to RUN. Busy rises the cycle after the edge. Otherwise hold.
  - RUN: each cycle ALUOut<=f(Func, A, ALUOut[3:0], ALUOut). If Iter==0, go to DONE; else Iter<=Iter-1.
  - DONE: Done=1 for exactly one cycle, Busy=0, then IDLE.
- Latency: for Count=N, the edge is seen at cycle 0, RUN occupies cycles 1..N+1, and Done is high at cycle N+2. The final ALUOut is visible from cycle N+2 and held until the next run or clear.
- Start edges in RUN or DONE are ignored, not queued. Start held high produces one run only; a new run needs Start to go low then high.
- Func/A/Count changes after acceptance have no effect on the current run.
- Clear in any state: ALUOut<=RESET_VAL, state<=IDLE, Busy=0, Done=0. Clear with a simultaneous start edge: clear wins and the edge is dropped.
- ALU functions, with B=ALUOut[3:0] and R=ALUOut. All results are 8-bit; the arithmetic carry out of bit 7 is discarded.
  - 0: {3'b0, A+B}, a 5-bit sum.
  - 1: {A^B, A|B}.
  - 2: 8'h01 if (A|B)!=0, else 8'h00.
  - 3: {A, ~B}.
  - 4: R << A[2:0], a logical shift.
  - 5: R >> A[2:0], a logical shift.
  - 6: A*B, a 4x4 unsigned product.
  - 7: R, a hold/no-op that still consumes iterations.
- Iter wraps never: the decrement happens only when Iter!=0.

Test Plan:
- Reset value: assert Reset_b=0 mid-RUN with Func=0, A=3, Count=5 -> ALUOut=8'h00, Busy=0 immediately (async), IDLE after release.
- Accumulate sum: ALUOut=00, Func=0, A=3, Count=2, pulse Start -> Busy high 3 cycles. ALUOut shows 03, 06, 09. Done pulses once. Final ALUOut=8'h09.
- Single-cycle concat: preload ALUOut=05 via run Func=0, A=5, Count=0, then Func=3, A=4'hA, Count=0 -> Busy high 1 cycle, ALUOut=8'hAA, Done at cycle 2.
- Product chain: preload 03, then Func=6, A=5, Count=1 -> ALUOut 0F then 4B.
- Shift plus ignored start: preload 01, then Func=4, A=1, Count=3, and toggle Start again during RUN -> ALUOut 02, 04, 08, 10. Exactly one Done. No second run.
- Clear priority: during RUN, assert Clear with a Start edge in the same cycle -> ALUOut=8'h00, Busy=0, no Done, state IDLE. Start held high afterward does not trigger a run.
